cash_dispenser: RTL and testbench
=================================

Name: cash_dispenser

Overview:
- Responder end of the withdraw path: accepts a dispense request (amount in 5-bit value units) from the ATM controller and physically pays it out.
- Holds a two-denomination cassette inventory: fives worth 5 units each, ones worth 1 unit each. Plans the payout greedily.
- Drives the note-feed motor one note at a time, confirms each note via a sensor, and reports Done, ErrStock or ErrJam back to the controller.

Parameters:
- VALUE_W, 5, width of DispAmount.
- CNT_W, 8, width of each inventory counter.
- INIT_FIVES, 20, five-unit notes loaded at reset.
- INIT_ONES, 50, one-unit notes loaded at reset.
- PULSE_CYCLES, 4, cycles FeedFive/FeedOne is held high per note.
- JAM_CYCLES, 16, max cycles to wait for NoteSensed after a pulse.
- GAP_CYCLES, 2, idle cycles between notes.

Ports:
- Clock  in  1  module clock, rising edge.
- Clear_n  in  1  asynchronous active-low reset.
- DispReq  in  1  request level; requester holds it until DispAck, then drops it.
- DispAmount  in  VALUE_W  amount requested; sampled on acceptance.
- DispAck  out  1  one-cycle pulse: request accepted.
- Busy  out  1  high whenever state is not IDLE.
- FeedFive  out  1  motor pulse for a five note.
- FeedOne  out  1  motor pulse for a one note.
- NoteSensed  in  1  sensor pulse: one note passed the exit.
- Done  out  1  one-cycle pulse: full amount paid.
- ErrStock  out  1  one-cycle pulse: inventory cannot cover the amount.
- ErrJam  out  1  level: jam latched.
- JamClear  in  1  clears a latched jam.
- RefillEn  in  1  adds RefillFives/RefillOnes to inventory; honoured in IDLE only.
- RefillFives  in  CNT_W  fives to add.
- RefillOnes  in  CNT_W  ones to add.
- FivesLeft  out  CNT_W  current five-note inventory.
- OnesLeft  out  CNT_W  current one-note inventory.

Behaviour:
- Reset (async, Clear_n=0):
  - state=IDLE.
  - All pulse and level outputs 0.
  - FivesLeft=INIT_FIVES, OnesLeft=INIT_ONES.
  - Plan and timer counters 0.
  - Reset mid-dispense abandons the payout; there is no partial-payment report.
- States: IDLE, CHECK, FEED, SENSE, GAP, DONE, JAMMED.
- IDLE, DispReq=1 at an edge:
  - Latch DispAmount, go to CHECK, pulse DispAck the next cycle.
  - DispReq still high on a later return to IDLE is treated as a new request.
- IDLE, RefillEn=1:
  - Each counter adds its refill value, saturating at 2^CNT_W-1.
  - Refill and DispReq on the same edge: refill applies first; CHECK sees the updated counts.
- RefillEn outside IDLE: ignored.
- CHECK (one cycle):
  - nf = min(amt/5, FivesLeft); no = amt - 5*nf.
  - no > OnesLeft: pulse ErrStock, go to IDLE, inventory unchanged.
  - amt=0: go to DONE.
  - Otherwise load the plan counters and go to FEED.
- FEED:
  - Fives are paid first, then ones.
  - Assert FeedFive (or FeedOne) for exactly PULSE_CYCLES, then go to SENSE. The timer restarts on entry to SENSE.
- SENSE:
  - NoteSensed seen within JAM_CYCLES: decrement the matching plan counter and inventory counter.
    - Plan now 0 for both denominations: go to DONE.
    - Otherwise go to GAP.
  - Timeout: set ErrJam, go to JAMMED. The un-sensed note is not decremented.
- NoteSensed outside SENSE: ignored.
- GAP: GAP_CYCLES idle cycles, then FEED.
- DONE: pulse Done for one cycle, go to IDLE.
- JAMMED:
  - Holds ErrJam=1 and ignores DispReq.
  - JamClear=1: ErrJam=0, plan cleared, go to IDLE.
- DispReq while Busy: ignored, no ack.
- Arithmetic: amt/5 and 5*nf are computed at VALUE_W+3 bits. Inventory never underflows, because CHECK guarantees coverage.
- Latency for amount A with no jam:
  - 2 cycles to the first FeedX: accept edge, then CHECK.
  - Each note takes PULSE_CYCLES + sense delay + GAP_CYCLES. The last note skips GAP.

Optional Feature:
- Macro: DISPENSER_AUDIT_EN.
- Defined: adds output TotalPaid[15:0] and output ReqCount[7:0].
  - TotalPaid adds 5 or 1 per sensed note and wraps modulo 2^16.
  - ReqCount increments on each DispAck and wraps at 256.
  - Both reset to 0.
- Undefined: both ports exist but are tied to 0; no counters are synthesized.

Test Plan:
- Reset defaults: reset, DispAmount=13 -> DispAck; 2 FeedFive pulses + 3 FeedOne pulses (each 4 cycles, sensor answered 3 cycles later); Done; FivesLeft=18, OnesLeft=47.
- Five shortfall: refill to fives=1, ones=50; amount 17 -> 1 five + 12 ones; FivesLeft=0, OnesLeft=38.
- Stock error: fives=0, ones=3; amount 4 -> ErrStock pulse, no Feed pulses, counts unchanged, Busy low the cycle after.
- Jam: amount 5, NoteSensed withheld -> after 4 + 16 cycles ErrJam=1, FivesLeft unchanged; DispReq ignored; JamClear -> IDLE.
- Simultaneous events: RefillEn with RefillOnes=255 at OnesLeft=50 -> saturates to 255; same edge DispReq amount=0 -> DispAck then Done, no Feed pulses. DispReq during FEED -> no ack.
- Async reset: Clear_n low mid-FEED -> FeedFive drops immediately, all counters return to INIT values; with DISPENSER_AUDIT_EN, TotalPaid=0.

Source files
------------

// File: rtl/cash_dispenser.sv
`timescale 1ns/1ps
// cash_dispenser
//   Pays out a requested amount from a two-denomination cassette (fives
//   worth 5 units, ones worth 1 unit). The payout is planned greedily,
//   then fed one note at a time, and each note is confirmed by the exit
//   sensor. Completion, stock shortfall or a latched jam is reported.
//
//   Optional build macro: DISPENSER_AUDIT_EN
//     defined   : TotalPaid / ReqCount count paid units and accepted requests
//     undefined : TotalPaid / ReqCount are tied to zero
//
// Ports
//   Clock, Clear_n           clock (rising edge), async active-low reset
//   DispReq, DispAmount      request level and amount (sampled on accept)
//   DispAck                  one-cycle accept pulse
//   Busy                     high whenever not idle
//   FeedFive, FeedOne        note-feed motor pulses
//   NoteSensed               exit sensor pulse, one per note
//   Done, ErrStock           one-cycle completion / shortfall pulses
//   ErrJam, JamClear         latched jam level and its clear input
//   RefillEn, RefillFives,
//   RefillOnes               inventory refill, honoured only when idle
//   FivesLeft, OnesLeft      current inventory
//   TotalPaid, ReqCount      audit counters (zero unless audit build)
module cash_dispenser #(
  parameter int unsigned VALUE_W      = 5,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned INIT_FIVES   = 20,
  parameter int unsigned INIT_ONES    = 50,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned JAM_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic               Clock,
  input  logic               Clear_n,
  input  logic               DispReq,
  input  logic [VALUE_W-1:0] DispAmount,
  output logic               DispAck,
  output logic               Busy,
  output logic               FeedFive,
  output logic               FeedOne,
  input  logic               NoteSensed,
  output logic               Done,
  output logic               ErrStock,
  output logic               ErrJam,
  input  logic               JamClear,
  input  logic               RefillEn,
  input  logic [CNT_W-1:0]   RefillFives,
  input  logic [CNT_W-1:0]   RefillOnes,
  output logic [CNT_W-1:0]   FivesLeft,
  output logic [CNT_W-1:0]   OnesLeft,
  output logic [15:0]        TotalPaid,
  output logic [7:0]         ReqCount
);

  localparam int unsigned AW   = VALUE_W + 3;
  localparam int unsigned MW   = (AW > CNT_W) ? AW : CNT_W;
  localparam int unsigned TMAX = (PULSE_CYCLES > JAM_CYCLES)
                               ? ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES)
                               : ((JAM_CYCLES > GAP_CYCLES) ? JAM_CYCLES : GAP_CYCLES);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] JAM_LAST   = TW'(JAM_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, FEED, SENSE, GAP, DONE, JAMMED
  } state_t;

  state_t state, state_next;

  logic [VALUE_W-1:0] amt;
  logic [AW-1:0]      five_plan, one_plan;
  logic [CNT_W-1:0]   fives, ones;
  logic [TW-1:0]      timer;

  logic [AW-1:0]      quot, nf, no_cnt;
  logic [AW:0]        plan_sum;
  logic               short, pay_five, last_note;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Greedy plan: as many fives as the amount and stock allow, rest in ones.
  always_comb begin
    quot = AW'(amt) / AW'(5);
    nf   = quot;
    if (MW'(quot) > MW'(fives)) nf = AW'(fives);
    no_cnt = AW'(amt) - AW'(5) * nf;
    short  = MW'(no_cnt) > MW'(ones);
  end

  assign pay_five  = (five_plan != '0);
  assign plan_sum  = {1'b0, five_plan} + {1'b0, one_plan};
  assign last_note = (plan_sum == (AW + 1)'(1));

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = (state != IDLE);
    DispAck    = 1'b0;
    FeedFive   = 1'b0;
    FeedOne    = 1'b0;
    Done       = 1'b0;
    ErrStock   = 1'b0;
    ErrJam     = 1'b0;
    case (state)
      IDLE: if (DispReq) state_next = CHECK;
      CHECK: begin
        DispAck = 1'b1;
        if (short) begin
          ErrStock   = 1'b1;
          state_next = IDLE;
        end else if (amt == '0) begin
          state_next = DONE;
        end else begin
          state_next = FEED;
        end
      end
      FEED: begin
        FeedFive = pay_five;
        FeedOne  = !pay_five;
        if (timer == PULSE_LAST) state_next = SENSE;
      end
      SENSE: begin
        if (NoteSensed)            state_next = last_note ? DONE : GAP;
        else if (timer == JAM_LAST) state_next = JAMMED;
      end
      GAP: if (timer == GAP_LAST) state_next = FEED;
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      JAMMED: begin
        ErrJam = 1'b1;
        if (JamClear) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Timer restarts on every state change so each timed phase counts from 0.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      timer <= '0;
    end else if (state_next != state) begin
      timer <= '0;
    end else if (state == FEED || state == SENSE || state == GAP) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      amt       <= '0;
      five_plan <= '0;
      one_plan  <= '0;
      fives     <= CNT_W'(INIT_FIVES);
      ones      <= CNT_W'(INIT_ONES);
    end else begin
      case (state)
        IDLE: begin
          if (RefillEn) begin
            fives <= sat_add(fives, RefillFives);
            ones  <= sat_add(ones, RefillOnes);
          end
          if (DispReq) amt <= DispAmount;
        end
        CHECK: begin
          if (!short && amt != '0) begin
            five_plan <= nf;
            one_plan  <= no_cnt;
          end
        end
        SENSE: begin
          if (NoteSensed) begin
            if (pay_five) begin
              five_plan <= five_plan - AW'(1);
              fives     <= fives - CNT_W'(1);
            end else begin
              one_plan  <= one_plan - AW'(1);
              ones      <= ones - CNT_W'(1);
            end
          end
        end
        JAMMED: begin
          if (JamClear) begin
            five_plan <= '0;
            one_plan  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign FivesLeft = fives;
  assign OnesLeft  = ones;

`ifdef DISPENSER_AUDIT_EN
  logic [15:0] total_paid;
  logic [7:0]  req_count;

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      total_paid <= '0;
      req_count  <= '0;
    end else begin
      if (state == SENSE && NoteSensed)
        total_paid <= total_paid + (pay_five ? 16'd5 : 16'd1);
      if (state == CHECK)
        req_count <= req_count + 8'd1;
    end
  end

  assign TotalPaid = total_paid;
  assign ReqCount  = req_count;
`else
  assign TotalPaid = '0;
  assign ReqCount  = '0;
`endif

endmodule

// File: tb/tb_cash_dispenser.sv
`timescale 1ns/1ps
// Bench for cash_dispenser: directed scenarios plus a randomized run, each
// checked against an arithmetic model of inventory, payout plan and timing.
module tb_cash_dispenser;

  localparam int VALUE_W    = 5;
  localparam int CNT_W      = 8;
  localparam int INIT_FIVES = 20;
  localparam int INIT_ONES  = 50;
  localparam int PULSE      = 4;
  localparam int JAM        = 16;
  localparam int GAP        = 2;
  localparam int SENSE_DLY  = 3;

  logic               Clock = 1'b0;
  logic               Clear_n = 1'b0;
  logic               DispReq = 1'b0;
  logic [VALUE_W-1:0] DispAmount = '0;
  logic               DispAck, Busy, FeedFive, FeedOne, Done, ErrStock, ErrJam;
  logic               NoteSensed = 1'b0;
  logic               JamClear = 1'b0;
  logic               RefillEn = 1'b0;
  logic [CNT_W-1:0]   RefillFives = '0;
  logic [CNT_W-1:0]   RefillOnes = '0;
  logic [CNT_W-1:0]   FivesLeft, OnesLeft;
  logic [15:0]        TotalPaid;
  logic [7:0]         ReqCount;

  cash_dispenser #(
    .VALUE_W(VALUE_W), .CNT_W(CNT_W), .INIT_FIVES(INIT_FIVES), .INIT_ONES(INIT_ONES),
    .PULSE_CYCLES(PULSE), .JAM_CYCLES(JAM), .GAP_CYCLES(GAP)
  ) dut (
    .Clock(Clock), .Clear_n(Clear_n), .DispReq(DispReq), .DispAmount(DispAmount),
    .DispAck(DispAck), .Busy(Busy), .FeedFive(FeedFive), .FeedOne(FeedOne),
    .NoteSensed(NoteSensed), .Done(Done), .ErrStock(ErrStock), .ErrJam(ErrJam),
    .JamClear(JamClear), .RefillEn(RefillEn), .RefillFives(RefillFives),
    .RefillOnes(RefillOnes), .FivesLeft(FivesLeft), .OnesLeft(OnesLeft),
    .TotalPaid(TotalPaid), .ReqCount(ReqCount)
  );

  always #5 Clock = ~Clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  int m_fives, m_ones, m_paid, m_reqs;

  // Feed-pulse monitor and sensor model
  int five_pulses = 0, one_pulses = 0, bad_pulses = 0;
  int run_len = 0, countdown = 0;
  bit run_five = 1'b0;
  bit sensor_en = 1'b1;

  always @(negedge Clock) begin
    if (!Clear_n) begin
      run_len = 0;
      countdown = 0;
      NoteSensed = 1'b0;
    end else begin
      NoteSensed = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) NoteSensed = 1'b1;
      end
      if (FeedFive === 1'b1 || FeedOne === 1'b1) begin
        if (run_len == 0) run_five = FeedFive;
        if (FeedFive === 1'b1 && FeedOne === 1'b1) bad_pulses++;
        run_len++;
      end else if (run_len > 0) begin
        if (run_len != PULSE) bad_pulses++;
        if (run_five) five_pulses++;
        else          one_pulses++;
        run_len = 0;
        if (sensor_en) countdown = SENSE_DLY;
      end
    end
  end

  function automatic logic [15:0] exp_paid();
`ifdef DISPENSER_AUDIT_EN
    return 16'(m_paid);
`else
    return '0;
`endif
  endfunction

  function automatic logic [7:0] exp_reqs();
`ifdef DISPENSER_AUDIT_EN
    return 8'(m_reqs);
`else
    return '0;
`endif
  endfunction

  // Greedy plan from the payout rules; updates the model inventory.
  // res: 1 = done, 2 = stock error. lat counts cycles from the accept
  // cycle to the Done cycle.
  function automatic void predict(input int amt, output int res, output int lat,
                                  output int nf, output int no);
    int n;
    nf = amt / 5;
    if (nf > m_fives) nf = m_fives;
    no = amt - 5 * nf;
    m_reqs++;
    if (no > m_ones) begin
      res = 2; lat = 0; nf = 0; no = 0;
    end else begin
      res = 1;
      m_fives -= nf;
      m_ones  -= no;
      m_paid  += 5 * nf + no;
      n = nf + no;
      lat = (n == 0) ? 1 : 1 + n * (PULSE + SENSE_DLY + 1) + (n - 1) * GAP;
    end
  endfunction

  task automatic do_reset();
    Clear_n = 1'b0; DispReq = 1'b0; RefillEn = 1'b0; JamClear = 1'b0; sensor_en = 1'b1;
    repeat (2) @(negedge Clock);
    Clear_n = 1'b1;
    @(negedge Clock);
    m_fives = INIT_FIVES; m_ones = INIT_ONES; m_paid = 0; m_reqs = 0;
  endtask

  task automatic refill(input int f, input int o);
    RefillEn = 1'b1; RefillFives = CNT_W'(f); RefillOnes = CNT_W'(o);
    @(negedge Clock);
    RefillEn = 1'b0;
    m_fives = (m_fives + f > 255) ? 255 : m_fives + f;
    m_ones  = (m_ones + o > 255) ? 255 : m_ones + o;
  endtask

  // Issue one request and observe the outcome. res: 0 none/timeout,
  // 1 Done, 2 ErrStock, 3 ErrJam. ff = cycles from accept to first feed.
  task automatic issue(input int amt, input int limit, output int res, output int ff,
                       output int lat, output int df, output int dn, output int db);
    int f0, o0, b0, n;
    f0 = five_pulses; o0 = one_pulses; b0 = bad_pulses;
    DispAmount = VALUE_W'(amt);
    DispReq = 1'b1;
    n = 0;
    @(negedge Clock);
    while (DispAck !== 1'b1 && n < 8) begin @(negedge Clock); n++; end
    DispReq = 1'b0;
    res = 0; ff = -1; lat = -1;
    if (DispAck === 1'b1) begin
      n = 0;
      while (!(Done === 1'b1 || ErrStock === 1'b1 || ErrJam === 1'b1) && n < limit) begin
        @(negedge Clock);
        n++;
        if (ff < 0 && (FeedFive === 1'b1 || FeedOne === 1'b1)) ff = n;
      end
      lat = n;
      if (Done === 1'b1)          res = 1;
      else if (ErrStock === 1'b1) res = 2;
      else if (ErrJam === 1'b1)   res = 3;
      if (res == 1 || res == 2) @(negedge Clock);
    end
    df = five_pulses - f0; dn = one_pulses - o0; db = bad_pulses - b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (FivesLeft !== CNT_W'(INIT_FIVES)) $display("FAIL reset_fives: got %0d expected %0d", FivesLeft, INIT_FIVES); else pass_cnt++;
    total_cnt++; if (OnesLeft !== CNT_W'(INIT_ONES)) $display("FAIL reset_ones: got %0d expected %0d", OnesLeft, INIT_ONES); else pass_cnt++;
    total_cnt++; if ({Busy, ErrJam, FeedFive, FeedOne} !== 4'b0) $display("FAIL reset_levels: got %b expected 0000", {Busy, ErrJam, FeedFive, FeedOne}); else pass_cnt++;
    total_cnt++; if ({DispAck, Done, ErrStock} !== 3'b0) $display("FAIL reset_pulses: got %b expected 000", {DispAck, Done, ErrStock}); else pass_cnt++;
    total_cnt++; if (TotalPaid !== exp_paid()) $display("FAIL reset_paid: got %0d expected %0d", TotalPaid, exp_paid()); else pass_cnt++;
    total_cnt++; if (ReqCount !== exp_reqs()) $display("FAIL reset_reqs: got %0d expected %0d", ReqCount, exp_reqs()); else pass_cnt++;
  endtask

  task automatic test_basic();
    int res, ff, lat, df, dn, db, eres, elat, enf, eno;
    predict(13, eres, elat, enf, eno);
    issue(13, 2000, res, ff, lat, df, dn, db);
    total_cnt++; if (res != eres) $display("FAIL basic_result: got %0d expected %0d", res, eres); else pass_cnt++;
    total_cnt++; if (ff != 1) $display("FAIL basic_first_feed: got %0d expected 1", ff); else pass_cnt++;
    total_cnt++; if (lat != elat) $display("FAIL basic_latency: got %0d expected %0d", lat, elat); else pass_cnt++;
    total_cnt++; if (df != enf || dn != eno) $display("FAIL basic_notes: got %0d/%0d expected %0d/%0d", df, dn, enf, eno); else pass_cnt++;
    total_cnt++; if (db != 0) $display("FAIL basic_pulse_shape: got %0d bad pulses expected 0", db); else pass_cnt++;
    total_cnt++; if (FivesLeft !== CNT_W'(m_fives) || OnesLeft !== CNT_W'(m_ones)) $display("FAIL basic_inventory: got %0d/%0d expected %0d/%0d", FivesLeft, OnesLeft, m_fives, m_ones); else pass_cnt++;
    total_cnt++; if (TotalPaid !== exp_paid()) $display("FAIL basic_paid: got %0d expected %0d", TotalPaid, exp_paid()); else pass_cnt++;
  endtask

  task automatic test_five_shortfall();
    int res, ff, lat, df, dn, db, eres, elat, enf, eno;
    int setup_amts[4] = '{30, 30, 30, 5};
    do_reset();
    foreach (setup_amts[i]) begin
      predict(setup_amts[i], eres, elat, enf, eno);
      issue(setup_amts[i], 2000, res, ff, lat, df, dn, db);
    end
    predict(17, eres, elat, enf, eno);
    issue(17, 2000, res, ff, lat, df, dn, db);
    total_cnt++; if (res != eres) $display("FAIL short_result: got %0d expected %0d", res, eres); else pass_cnt++;
    total_cnt++; if (df != enf || dn != eno) $display("FAIL short_notes: got %0d/%0d expected %0d/%0d", df, dn, enf, eno); else pass_cnt++;
    total_cnt++; if (lat != elat) $display("FAIL short_latency: got %0d expected %0d", lat, elat); else pass_cnt++;
    total_cnt++; if (FivesLeft !== CNT_W'(m_fives) || OnesLeft !== CNT_W'(m_ones)) $display("FAIL short_inventory: got %0d/%0d expected %0d/%0d", FivesLeft, OnesLeft, m_fives, m_ones); else pass_cnt++;
  endtask

  task automatic test_stock_error();
    int res, ff, lat, df, dn, db, eres, elat, enf, eno;
    predict(31, eres, elat, enf, eno);
    issue(31, 2000, res, ff, lat, df, dn, db);
    predict(4, eres, elat, enf, eno);
    issue(4, 2000, res, ff, lat, df, dn, db);
    predict(4, eres, elat, enf, eno);
    issue(4, 2000, res, ff, lat, df, dn, db);
    total_cnt++; if (res != eres) $display("FAIL stock_result: got %0d expected %0d", res, eres); else pass_cnt++;
    total_cnt++; if (lat != 0) $display("FAIL stock_latency: got %0d expected 0", lat); else pass_cnt++;
    total_cnt++; if (df + dn != 0) $display("FAIL stock_no_feed: got %0d pulses expected 0", df + dn); else pass_cnt++;
    total_cnt++; if (FivesLeft !== CNT_W'(m_fives) || OnesLeft !== CNT_W'(m_ones)) $display("FAIL stock_inventory: got %0d/%0d expected %0d/%0d", FivesLeft, OnesLeft, m_fives, m_ones); else pass_cnt++;
    total_cnt++; if (Busy !== 1'b0) $display("FAIL stock_busy_after: got %b expected 0", Busy); else pass_cnt++;
    total_cnt++; if (ReqCount !== exp_reqs()) $display("FAIL stock_reqs: got %0d expected %0d", ReqCount, exp_reqs()); else pass_cnt++;
  endtask

  task automatic test_jam();
    int res, ff, lat, df, dn, db, eres, elat, enf, eno, acks, jam_lost;
    refill(10, 0);
    sensor_en = 1'b0;
    m_reqs++;
    issue(5, 200, res, ff, lat, df, dn, db);
    total_cnt++; if (res != 3) $display("FAIL jam_result: got %0d expected 3", res); else pass_cnt++;
    total_cnt++; if (lat != 1 + PULSE + JAM) $display("FAIL jam_latency: got %0d expected %0d", lat, 1 + PULSE + JAM); else pass_cnt++;
    total_cnt++; if (df != 1 || dn != 0) $display("FAIL jam_notes: got %0d/%0d expected 1/0", df, dn); else pass_cnt++;
    total_cnt++; if (FivesLeft !== CNT_W'(m_fives)) $display("FAIL jam_fives_kept: got %0d expected %0d", FivesLeft, m_fives); else pass_cnt++;
    DispAmount = 5'd3; DispReq = 1'b1; acks = 0; jam_lost = 0;
    repeat (5) begin
      @(negedge Clock);
      if (DispAck === 1'b1) acks++;
      if (ErrJam !== 1'b1) jam_lost++;
    end
    DispReq = 1'b0;
    total_cnt++; if (acks != 0) $display("FAIL jam_req_ignored: got %0d acks expected 0", acks); else pass_cnt++;
    total_cnt++; if (jam_lost != 0) $display("FAIL jam_held: got %0d low cycles expected 0", jam_lost); else pass_cnt++;
    JamClear = 1'b1;
    @(negedge Clock);
    JamClear = 1'b0;
    sensor_en = 1'b1;
    total_cnt++; if ({ErrJam, Busy} !== 2'b00) $display("FAIL jam_clear: got %b expected 00", {ErrJam, Busy}); else pass_cnt++;
    predict(5, eres, elat, enf, eno);
    issue(5, 2000, res, ff, lat, df, dn, db);
    total_cnt++; if (res != eres || FivesLeft !== CNT_W'(m_fives)) $display("FAIL jam_recover: got %0d/%0d expected %0d/%0d", res, FivesLeft, eres, m_fives); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int f0, o0;
    do_reset();
    f0 = five_pulses; o0 = one_pulses;
    RefillEn = 1'b1; RefillFives = '0; RefillOnes = 8'd255;
    DispReq = 1'b1; DispAmount = '0;
    @(negedge Clock);
    RefillEn = 1'b0; DispReq = 1'b0;
    m_ones = 255; m_reqs++;
    total_cnt++; if (DispAck !== 1'b1) $display("FAIL simul_ack: got %b expected 1", DispAck); else pass_cnt++;
    total_cnt++; if (OnesLeft !== CNT_W'(m_ones) || FivesLeft !== CNT_W'(m_fives)) $display("FAIL simul_saturate: got %0d/%0d expected %0d/%0d", FivesLeft, OnesLeft, m_fives, m_ones); else pass_cnt++;
    @(negedge Clock);
    total_cnt++; if (Done !== 1'b1) $display("FAIL simul_zero_done: got %b expected 1", Done); else pass_cnt++;
    @(negedge Clock);
    total_cnt++; if (five_pulses - f0 + one_pulses - o0 != 0 || Busy !== 1'b0) $display("FAIL simul_no_feed: got %0d pulses busy %b expected 0 0", five_pulses - f0 + one_pulses - o0, Busy); else pass_cnt++;
  endtask

  task automatic test_busy_ignored();
    int n, acks;
    DispAmount = 5'd5; DispReq = 1'b1; n = 0;
    @(negedge Clock);
    while (DispAck !== 1'b1 && n < 8) begin @(negedge Clock); n++; end
    DispReq = 1'b0;
    m_reqs++;
    n = 0;
    while (FeedFive !== 1'b1 && n < 10) begin @(negedge Clock); n++; end
    total_cnt++; if (FeedFive !== 1'b1) $display("FAIL busy_feed_start: got %b expected 1", FeedFive); else pass_cnt++;
    DispAmount = 5'd7; DispReq = 1'b1;
    RefillEn = 1'b1; RefillFives = 8'd5; RefillOnes = 8'd5;
    acks = 0;
    repeat (3) begin @(negedge Clock); if (DispAck === 1'b1) acks++; end
    DispReq = 1'b0; RefillEn = 1'b0;
    n = 0;
    while (Done !== 1'b1 && n < 100) begin @(negedge Clock); n++; end
    m_fives -= 1; m_paid += 5;
    total_cnt++; if (acks != 0) $display("FAIL busy_no_ack: got %0d acks expected 0", acks); else pass_cnt++;
    total_cnt++; if (Done !== 1'b1) $display("FAIL busy_done: got %b expected 1", Done); else pass_cnt++;
    @(negedge Clock);
    total_cnt++; if (FivesLeft !== CNT_W'(m_fives) || OnesLeft !== CNT_W'(m_ones)) $display("FAIL busy_refill_ignored: got %0d/%0d expected %0d/%0d", FivesLeft, OnesLeft, m_fives, m_ones); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acks, dones, idle_seen;
    DispAmount = '0; DispReq = 1'b1;
    acks = 0; dones = 0; idle_seen = 0;
    repeat (6) begin
      @(negedge Clock);
      if (DispAck === 1'b1) acks++;
      if (Done === 1'b1) dones++;
      if (Busy === 1'b0) idle_seen++;
    end
    DispReq = 1'b0;
    m_reqs += 2;
    @(negedge Clock);
    total_cnt++; if (acks != 2 || dones != 2) $display("FAIL b2b_count: got %0d acks %0d dones expected 2 2", acks, dones); else pass_cnt++;
    total_cnt++; if (idle_seen != 2) $display("FAIL b2b_busy: got %0d idle cycles expected 2", idle_seen); else pass_cnt++;
    total_cnt++; if (Busy !== 1'b0) $display("FAIL b2b_stop: got %b expected 0", Busy); else pass_cnt++;
  endtask

  task automatic test_random();
    int res, ff, lat, df, dn, db, eres, elat, enf, eno, amt, eff;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) refill($urandom_range(0, 4), $urandom_range(0, 20));
      amt = $urandom_range(0, 31);
      predict(amt, eres, elat, enf, eno);
      eff = (enf + eno > 0) ? 1 : -1;
      issue(amt, 2000, res, ff, lat, df, dn, db);
      total_cnt++; if (res != eres || lat != elat || ff != eff) $display("FAIL rand_outcome[%0d] amt %0d: got res %0d lat %0d ff %0d expected %0d %0d %0d", i, amt, res, lat, ff, eres, elat, eff); else pass_cnt++;
      total_cnt++; if (df != enf || dn != eno || db != 0) $display("FAIL rand_notes[%0d] amt %0d: got %0d/%0d bad %0d expected %0d/%0d bad 0", i, amt, df, dn, db, enf, eno); else pass_cnt++;
      total_cnt++; if (FivesLeft !== CNT_W'(m_fives) || OnesLeft !== CNT_W'(m_ones)) $display("FAIL rand_inventory[%0d]: got %0d/%0d expected %0d/%0d", i, FivesLeft, OnesLeft, m_fives, m_ones); else pass_cnt++;
    end
    total_cnt++; if (TotalPaid !== exp_paid()) $display("FAIL rand_paid: got %0d expected %0d", TotalPaid, exp_paid()); else pass_cnt++;
    total_cnt++; if (ReqCount !== exp_reqs()) $display("FAIL rand_reqs: got %0d expected %0d", ReqCount, exp_reqs()); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    DispAmount = 5'd10; DispReq = 1'b1; n = 0;
    @(negedge Clock);
    while (DispAck !== 1'b1 && n < 8) begin @(negedge Clock); n++; end
    DispReq = 1'b0;
    n = 0;
    while (FeedFive !== 1'b1 && n < 10) begin @(negedge Clock); n++; end
    total_cnt++; if (FeedFive !== 1'b1) $display("FAIL areset_feed_start: got %b expected 1", FeedFive); else pass_cnt++;
    #2 Clear_n = 1'b0;
    #1;
    m_fives = INIT_FIVES; m_ones = INIT_ONES; m_paid = 0; m_reqs = 0;
    total_cnt++; if ({FeedFive, FeedOne, Busy} !== 3'b000) $display("FAIL areset_outputs: got %b expected 000", {FeedFive, FeedOne, Busy}); else pass_cnt++;
    total_cnt++; if (FivesLeft !== CNT_W'(m_fives) || OnesLeft !== CNT_W'(m_ones)) $display("FAIL areset_inventory: got %0d/%0d expected %0d/%0d", FivesLeft, OnesLeft, m_fives, m_ones); else pass_cnt++;
    total_cnt++; if (TotalPaid !== exp_paid() || ReqCount !== exp_reqs()) $display("FAIL areset_audit: got %0d/%0d expected %0d/%0d", TotalPaid, ReqCount, exp_paid(), exp_reqs()); else pass_cnt++;
    repeat (2) @(negedge Clock);
    Clear_n = 1'b1;
    repeat (3) @(negedge Clock);
    total_cnt++; if ({Busy, Done, FeedFive, FeedOne} !== 4'b0) $display("FAIL areset_stays_idle: got %b expected 0000", {Busy, Done, FeedFive, FeedOne}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_five_shortfall();
    test_stock_error();
    test_jam();
    test_simultaneous();
    test_busy_ignored();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
